// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CLS_OP, CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_NONE
  } iclass_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ImmExtend select codes
  localparam logic [2:0] ITYPE = 3'd0;
  localparam logic [2:0] STYPE = 3'd1;
  localparam logic [2:0] BTYPE = 3'd2;
  localparam logic [2:0] UTYPE = 3'd3;
  localparam logic [2:0] JTYPE = 3'd4;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_opdecode.sv
// Combinational opcode classifier: opcode -> immediate type, class, legality.
module multicycle_ctrl_opdecode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_type,
  output iclass_t    iclass,
  output logic       legal
);

  // Table lookup; OP reports ITYPE but callers leave their imm select untouched for it
  always_comb begin
    imm_type = ITYPE;
    iclass   = CLS_NONE;
    legal    = 1'b1;
    case (opcode)
      OPC_OP:     iclass = CLS_OP;
      OPC_OPIMM:  iclass = CLS_OPIMM;
      OPC_LOAD:   iclass = CLS_LOAD;
      OPC_JALR:   iclass = CLS_JALR;
      OPC_STORE:  begin iclass = CLS_STORE;  imm_type = STYPE; end
      OPC_BRANCH: begin iclass = CLS_BRANCH; imm_type = BTYPE; end
      OPC_LUI:    begin iclass = CLS_LUI;    imm_type = UTYPE; end
      OPC_AUIPC:  begin iclass = CLS_AUIPC;  imm_type = UTYPE; end
      OPC_JAL:    begin iclass = CLS_JAL;    imm_type = JTYPE; end
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FSM, memory wait timeout, datapath enables.
//
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | instruction memory request, load IR on ready
//   DECODE | latch opcode, select immediate type
//   EXEC   | ALU operand select, branch resolution
//   MEM    | data memory access, hold until ready
//   WB     | register write-back and PC update
//   TRAP   | illegal opcode or memory timeout, left only by reset
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit          RESET_TO_FETCH = 1'b1,
  parameter int unsigned MAX_WAIT       = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] inst,
  input  logic        br_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_type,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        busy
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t     state, state_nx;
  logic [6:0] opcode_q;
  logic [7:0] wait_cnt, wait_inc;
  logic       waiting, wait_hit;
  logic [6:0] dec_in;
  logic [2:0] dec_imm;
  iclass_t    dec_cls;
  logic       dec_legal;
  logic       inst_unused;

  // Only the opcode field is consumed here; the rest feeds the datapath
  assign inst_unused = ^inst[31:7];

  // In DECODE classify the fresh IR contents; afterwards the latched opcode
  assign dec_in = (state == S_DECODE) ? inst[6:0] : opcode_q;

  multicycle_ctrl_opdecode u_opdecode (
    .opcode   (dec_in),
    .imm_type (dec_imm),
    .iclass   (dec_cls),
    .legal    (dec_legal)
  );

  assign waiting  = ((state == S_FETCH) && !imem_ready) || ((state == S_MEM) && !dmem_ready);
  assign wait_inc = wait_cnt + 8'd1;
  // Timeout fires on the not-ready cycle that would bring the count to MAX_WAIT
  assign wait_hit = (MAX_WAIT_C != 8'd0) && waiting && (wait_inc == MAX_WAIT_C);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RESET_TO_FETCH ? S_FETCH : S_IDLE;
    else     state <= state_nx;
  end

  // Opcode latch, immediate select, sticky illegal flag and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= 7'd0;
      imm_type <= ITYPE;
      illegal  <= 1'b0;
      wait_cnt <= 8'd0;
    end else begin
      if (state == S_DECODE) begin
        opcode_q <= inst[6:0];
        if (dec_legal && (dec_cls != CLS_OP)) imm_type <= dec_imm;
      end
      if ((state_nx == S_TRAP) && (state != S_TRAP)) illegal <= 1'b1;
      if (state_nx != state)                       wait_cnt <= 8'd0;
      else if (waiting && (wait_cnt != 8'hFF))     wait_cnt <= wait_inc;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_FETCH;
      S_FETCH:  if (imem_ready) state_nx = S_DECODE;
                else if (wait_hit) state_nx = S_TRAP;
      S_DECODE: state_nx = dec_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (dec_cls)
          CLS_BRANCH:          state_nx = S_FETCH;
          CLS_LOAD, CLS_STORE: state_nx = S_MEM;
          default:             state_nx = S_WB;
        endcase
      end
      S_MEM:    if (dmem_ready) state_nx = (dec_cls == CLS_STORE) ? S_FETCH : S_WB;
                else if (wait_hit) state_nx = S_TRAP;
      S_WB:     state_nx = S_FETCH;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_TRAP;
    endcase
  end

  // Output decode; reset suppresses every request and enable in its own cycle
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    busy      = 1'b0;
    if (!rst) begin
      busy = (state != S_IDLE) && (state != S_TRAP);
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_EXEC: begin
          alu_src_b = (dec_cls != CLS_OP) && (dec_cls != CLS_BRANCH);
          alu_src_a = (dec_cls == CLS_AUIPC);
          if (dec_cls == CLS_BRANCH) begin
            pc_we  = 1'b1;
            pc_src = br_taken ? PC_IMM : PC_PLUS4;
          end
          if (dec_cls == CLS_JAL)  pc_src = PC_IMM;
          if (dec_cls == CLS_JALR) pc_src = PC_ALU;
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (dec_cls == CLS_STORE);
          pc_we    = dmem_ready && (dec_cls == CLS_STORE);
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          case (dec_cls)
            CLS_LOAD: wb_sel = WB_MEM;
            CLS_JAL:  begin wb_sel = WB_PC4; pc_src = PC_IMM; end
            CLS_JALR: begin wb_sel = WB_PC4; pc_src = PC_ALU; end
            default:  wb_sel = WB_ALU;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues per-cycle expectations, a monitor checks them.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, br_taken, imem_ready, dmem_ready;
  logic [31:0] inst;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  imm_type;
  logic        alu_src_a, alu_src_b, reg_we, illegal, busy;

  multicycle_ctrl #(.RESET_TO_FETCH(1'b1), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .inst(inst), .br_taken(br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .imm_type(imm_type), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0] pc_src;
    logic [2:0] imm_type;
    logic       alu_src_a, alu_src_b, reg_we;
    logic [1:0] wb_sel;
    logic       illegal, busy;
  } obs_t;

  typedef struct {
    obs_t  exp;
    obs_t  mask;
    string name;
  } item_t;

  localparam logic [31:0] ADDI  = 32'hFFC60613;
  localparam logic [31:0] BEQ   = 32'b0000000_01010_10011_000_10000_1100011;
  localparam logic [31:0] SW    = 32'b0000000_01110_00010_010_01000_0100011;
  localparam logic [31:0] LW    = 32'h0002A303;
  localparam logic [31:0] JAL   = 32'h008000EF;
  localparam logic [31:0] JALR  = 32'h000080E7;
  localparam logic [31:0] AUIPC = 32'h00000297;
  localparam logic [31:0] ADD   = 32'h00B50533;

  item_t sb[$];
  item_t mit;
  obs_t  act;
  int    checks   = 0;
  int    failures = 0;

  assign act = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, imm_type,
                alu_src_a, alu_src_b, reg_we, wb_sel, illegal, busy};

  function automatic obs_t m_all();
    obs_t m = '1;
    return m;
  endfunction

  function automatic obs_t m_noalu();
    obs_t m = '1;
    m.alu_src_a = 1'b0;
    m.alu_src_b = 1'b0;
    return m;
  endfunction

  function automatic obs_t m_rst();
    obs_t m = m_noalu();
    m.imm_type = 3'd0;
    m.illegal  = 1'b0;
    return m;
  endfunction

  function automatic obs_t o_base(input logic [2:0] imm);
    obs_t o = '0;
    o.imm_type = imm;
    o.busy     = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_fetch(input logic [2:0] imm, input logic rdy);
    obs_t o = o_base(imm);
    o.imem_req = 1'b1;
    o.ir_we    = rdy;
    return o;
  endfunction

  function automatic obs_t o_exec(input logic [2:0] imm, input logic a, input logic b,
                                  input logic pcwe, input logic [1:0] pcs);
    obs_t o = o_base(imm);
    o.alu_src_a = a;
    o.alu_src_b = b;
    o.pc_we     = pcwe;
    o.pc_src    = pcs;
    return o;
  endfunction

  function automatic obs_t o_mem(input logic [2:0] imm, input logic we, input logic pcwe);
    obs_t o = o_base(imm);
    o.dmem_req = 1'b1;
    o.dmem_we  = we;
    o.pc_we    = pcwe;
    return o;
  endfunction

  function automatic obs_t o_wb(input logic [2:0] imm, input logic [1:0] wbs, input logic [1:0] pcs);
    obs_t o = o_base(imm);
    o.reg_we = 1'b1;
    o.pc_we  = 1'b1;
    o.wb_sel = wbs;
    o.pc_src = pcs;
    return o;
  endfunction

  function automatic obs_t o_trap(input logic [2:0] imm);
    obs_t o = '0;
    o.imm_type = imm;
    o.illegal  = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_quiet(input logic [2:0] imm);
    obs_t o = '0;
    o.imm_type = imm;
    return o;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic step(input string nm, input logic r, input logic [31:0] i,
                      input logic ir_rdy, input logic dm_rdy, input logic bt,
                      input obs_t e, input obs_t m);
    item_t it;
    rst        = r;
    inst       = i;
    imem_ready = ir_rdy;
    dmem_ready = dm_rdy;
    br_taken   = bt;
    it.exp  = e;
    it.mask = m;
    it.name = nm;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mit = sb.pop_front();
        checks++;
        if (((act ^ mit.exp) & mit.mask) != '0) begin
          failures++;
          $display("FAIL %s: got %05h want %05h (mask %05h)", mit.name, act, mit.exp, mit.mask);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; inst = 32'd0;
    br_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    step("reset",       1, 32'd0, 0, 0, 0, o_quiet(ITYPE), m_noalu());

    // addi, ready always 1
    step("addi_fetch",  0, ADDI, 1, 1, 0, o_fetch(ITYPE, 1), m_noalu());
    step("addi_decode", 0, ADDI, 1, 1, 0, o_base(ITYPE), m_noalu());
    step("addi_exec",   0, ADDI, 1, 1, 0, o_exec(ITYPE, 0, 1, 0, PC_PLUS4), m_all());
    step("addi_wb",     0, ADDI, 1, 1, 0, o_wb(ITYPE, WB_ALU, PC_PLUS4), m_noalu());

    // branch taken, then not taken
    step("bt_fetch",    0, BEQ, 1, 0, 1, o_fetch(ITYPE, 1), m_noalu());
    step("bt_decode",   0, BEQ, 1, 0, 1, o_base(ITYPE), m_noalu());
    step("bt_exec",     0, BEQ, 1, 0, 1, o_exec(BTYPE, 0, 0, 1, PC_IMM), m_all());
    step("bn_fetch",    0, BEQ, 1, 0, 0, o_fetch(BTYPE, 1), m_noalu());
    step("bn_decode",   0, BEQ, 1, 0, 0, o_base(BTYPE), m_noalu());
    step("bn_exec",     0, BEQ, 1, 0, 0, o_exec(BTYPE, 0, 0, 1, PC_PLUS4), m_all());

    // store, dmem_ready after 3 wait cycles
    step("sw_fetch",    0, SW, 1, 0, 0, o_fetch(BTYPE, 1), m_noalu());
    step("sw_decode",   0, SW, 1, 0, 0, o_base(BTYPE), m_noalu());
    step("sw_exec",     0, SW, 1, 0, 0, o_exec(STYPE, 0, 1, 0, PC_PLUS4), m_all());
    for (int k = 0; k < 3; k++)
      step("sw_mem_wait", 0, SW, 1, 0, 0, o_mem(STYPE, 1, 0), m_noalu());
    step("sw_mem_rdy",  0, SW, 1, 1, 0, o_mem(STYPE, 1, 1), m_noalu());

    // load then jal
    step("lw_fetch",    0, LW, 1, 1, 0, o_fetch(STYPE, 1), m_noalu());
    step("lw_decode",   0, LW, 1, 1, 0, o_base(STYPE), m_noalu());
    step("lw_exec",     0, LW, 1, 1, 0, o_exec(ITYPE, 0, 1, 0, PC_PLUS4), m_all());
    step("lw_mem",      0, LW, 1, 1, 0, o_mem(ITYPE, 0, 0), m_noalu());
    step("lw_wb",       0, LW, 1, 1, 0, o_wb(ITYPE, WB_MEM, PC_PLUS4), m_noalu());
    step("jal_fetch",   0, JAL, 1, 1, 0, o_fetch(ITYPE, 1), m_noalu());
    step("jal_decode",  0, JAL, 1, 1, 0, o_base(ITYPE), m_noalu());
    step("jal_exec",    0, JAL, 1, 1, 0, o_exec(JTYPE, 0, 1, 0, PC_IMM), m_all());
    step("jal_wb",      0, JAL, 1, 1, 0, o_wb(JTYPE, WB_PC4, PC_IMM), m_noalu());

    // jalr, auipc, add (add keeps previous imm_type)
    step("jalr_fetch",  0, JALR, 1, 1, 0, o_fetch(JTYPE, 1), m_noalu());
    step("jalr_decode", 0, JALR, 1, 1, 0, o_base(JTYPE), m_noalu());
    step("jalr_exec",   0, JALR, 1, 1, 0, o_exec(ITYPE, 0, 1, 0, PC_ALU), m_all());
    step("jalr_wb",     0, JALR, 1, 1, 0, o_wb(ITYPE, WB_PC4, PC_ALU), m_noalu());
    step("auipc_fetch", 0, AUIPC, 1, 1, 0, o_fetch(ITYPE, 1), m_noalu());
    step("auipc_decode",0, AUIPC, 1, 1, 0, o_base(ITYPE), m_noalu());
    step("auipc_exec",  0, AUIPC, 1, 1, 0, o_exec(UTYPE, 1, 1, 0, PC_PLUS4), m_all());
    step("auipc_wb",    0, AUIPC, 1, 1, 0, o_wb(UTYPE, WB_ALU, PC_PLUS4), m_noalu());
    step("add_fetch",   0, ADD, 1, 1, 0, o_fetch(UTYPE, 1), m_noalu());
    step("add_decode",  0, ADD, 1, 1, 0, o_base(UTYPE), m_noalu());
    step("add_exec",    0, ADD, 1, 1, 0, o_exec(UTYPE, 0, 0, 0, PC_PLUS4), m_all());
    step("add_wb",      0, ADD, 1, 1, 0, o_wb(UTYPE, WB_ALU, PC_PLUS4), m_noalu());

    // fetch timeout with MAX_WAIT=4
    for (int k = 0; k < 4; k++)
      step("to_fetch_wait", 0, ADDI, 0, 0, 0, o_fetch(UTYPE, 0), m_noalu());
    step("to_trap0",    0, ADDI, 1, 1, 0, o_trap(UTYPE), m_noalu());
    step("to_trap1",    0, ADDI, 1, 1, 0, o_trap(UTYPE), m_noalu());
    step("to_rst",      1, ADDI, 1, 1, 0, o_quiet(ITYPE), m_rst());

    // ready in the 4th wait cycle wins over the timeout
    for (int k = 0; k < 3; k++)
      step("rw_fetch_wait", 0, ADDI, 0, 0, 0, o_fetch(ITYPE, 0), m_noalu());
    step("rw_fetch_rdy",0, ADDI, 1, 0, 0, o_fetch(ITYPE, 1), m_noalu());
    step("rw_decode",   0, ADDI, 1, 0, 0, o_base(ITYPE), m_noalu());
    step("rw_exec",     0, ADDI, 1, 0, 0, o_exec(ITYPE, 0, 1, 0, PC_PLUS4), m_all());
    step("rw_wb",       0, ADDI, 1, 0, 0, o_wb(ITYPE, WB_ALU, PC_PLUS4), m_noalu());

    // illegal opcode
    step("ill_fetch",   0, 32'd0, 1, 1, 0, o_fetch(ITYPE, 1), m_noalu());
    step("ill_decode",  0, 32'd0, 1, 1, 0, o_base(ITYPE), m_noalu());
    step("ill_trap0",   0, 32'd0, 1, 1, 1, o_trap(ITYPE), m_rst() | obs_t'(17'h00001 << 1));
    step("ill_trap1",   0, 32'd0, 1, 1, 1, o_trap(ITYPE), m_rst() | obs_t'(17'h00001 << 1));
    step("ill_rst",     1, 32'd0, 1, 1, 0, o_quiet(ITYPE), m_rst());

    // restart after reset, then reset in the middle of a store's MEM with ready
    step("re_fetch",    0, SW, 1, 0, 0, o_fetch(ITYPE, 1), m_noalu());
    step("re_decode",   0, SW, 1, 0, 0, o_base(ITYPE), m_noalu());
    step("re_exec",     0, SW, 1, 0, 0, o_exec(STYPE, 0, 1, 0, PC_PLUS4), m_all());
    step("re_mem",      0, SW, 1, 0, 0, o_mem(STYPE, 1, 0), m_noalu());
    step("re_mem_rst",  1, SW, 1, 1, 0, o_quiet(ITYPE), m_rst());
    step("re_after",    0, SW, 0, 0, 0, o_fetch(ITYPE, 0), m_noalu());

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
